// File: rtl/anim_frame_sequencer.sv
// anim_frame_sequencer: per-animation frame stepping for the 7-segment animation engine.
// Holds the frame-count table, divides clk down to a step rate and walks the frame
// index in loop, ping-pong, one-shot or hold mode.
// Optional build macro ANIM_SEQ_LFSR_EN turns mode 11 into a pseudo-random frame mode.
module anim_frame_sequencer #(
  parameter int unsigned ANIM_W     = 5,
  parameter int unsigned FRAME_W    = 5,
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [ANIM_W-1:0]     animation,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] tick_div,
  output logic [FRAME_W-1:0]    frame,
  output logic                  frame_strobe,
  output logic                  done,
  output logic [FRAME_W:0]      limit
);

  typedef enum logic [1:0] {
    MODE_LOOP = 2'b00,
    MODE_PING = 2'b01,
    MODE_ONCE = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam int unsigned LIM_W = FRAME_W + 1;
  localparam int unsigned AX_W  = ANIM_W + 6;

  localparam logic [5:0] LIMIT_TBL [32] = '{
    6'd10, 6'd12, 6'd6,  6'd6,  6'd6,  6'd6,  6'd6,  6'd2,
    6'd4,  6'd4,  6'd2,  6'd2,  6'd2,  6'd2,  6'd2,  6'd4,
    6'd6,  6'd2,  6'd7,  6'd7,  6'd7,  6'd7,  6'd7,  6'd4,
    6'd16, 6'd16, 6'd16, 6'd1,  6'd1,  6'd1,  6'd1,  6'd32
  };

  logic [ANIM_W-1:0]     anim_q;
  mode_e                 mode_q;
  logic                  dir_down;
  logic [PRESCALE_W-1:0] presc;
  logic                  restart_c;
  logic                  step_c;
  logic [AX_W-1:0]       anim_x_c;
  logic [LIM_W-1:0]      frame_x_c;
  logic [LIM_W-1:0]      lim_m1_c;
  logic                  at_top_c;

  // Frame count of the latched animation; out-of-table indices give a single frame.
  always_comb begin
    anim_x_c = AX_W'(anim_q);
    if (anim_x_c >= AX_W'(32)) limit = LIM_W'(1);
    else                       limit = LIM_W'(LIMIT_TBL[anim_x_c[4:0]]);
  end

  // Restart/step qualifiers and end-of-range helpers.
  always_comb begin
    restart_c = (animation != anim_q) || (mode != mode_q);
    step_c    = ena && (presc == tick_div);
    frame_x_c = LIM_W'(frame);
    lim_m1_c  = limit - LIM_W'(1);
    at_top_c  = (frame_x_c == lim_m1_c);
  end

`ifdef ANIM_SEQ_LFSR_EN
  logic [7:0]       lfsr;
  logic [7:0]       lfsr_nxt_c;
  logic [LIM_W-1:0] cand_c;
  logic [LIM_W-1:0] cand_sub_c;
  logic [FRAME_W-1:0] rand_frame_c;

  // Next LFSR state (x^8+x^6+x^5+x^4+1) and its folding into the frame range.
  always_comb begin
    lfsr_nxt_c = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    cand_c     = LIM_W'(lfsr_nxt_c[FRAME_W-1:0]);
    cand_sub_c = cand_c - limit;
    if (cand_c < limit)          rand_frame_c = FRAME_W'(cand_c);
    else if (cand_sub_c < limit) rand_frame_c = FRAME_W'(cand_sub_c);
    else                         rand_frame_c = '0;
  end

  // LFSR advances once per step and survives restarts.
  always_ff @(posedge clk) begin
    if (rst)                       lfsr <= 8'h01;
    else if (!restart_c && step_c) lfsr <= lfsr_nxt_c;
  end
`endif

  // Sequencer state: restart latch, prescaler and per-mode frame stepping.
  always_ff @(posedge clk) begin
    if (rst) begin
      anim_q       <= '0;
      mode_q       <= MODE_LOOP;
      frame        <= '0;
      dir_down     <= 1'b0;
      presc        <= '0;
      done         <= 1'b0;
      frame_strobe <= 1'b0;
    end else if (restart_c) begin
      anim_q       <= animation;
      mode_q       <= mode_e'(mode);
      frame        <= '0;
      dir_down     <= 1'b0;
      presc        <= '0;
      done         <= 1'b0;
      frame_strobe <= 1'b1;
    end else begin
      frame_strobe <= 1'b0;
      if (ena) begin
        if (step_c) presc <= '0;
        else        presc <= presc + PRESCALE_W'(1);
      end
      if (step_c) begin
        case (mode_q)
          MODE_LOOP: begin
            frame        <= at_top_c ? '0 : frame + FRAME_W'(1);
            frame_strobe <= 1'b1;
          end
          MODE_PING: begin
            frame_strobe <= 1'b1;
            if (limit == LIM_W'(1)) begin
              frame <= '0;
            end else if (!dir_down) begin
              if (at_top_c) begin
                dir_down <= 1'b1;
                frame    <= FRAME_W'(lim_m1_c - LIM_W'(1));
              end else begin
                frame <= frame + FRAME_W'(1);
              end
            end else begin
              if (frame == '0) begin
                dir_down <= 1'b0;
                frame    <= FRAME_W'(1);
              end else begin
                frame <= frame - FRAME_W'(1);
              end
            end
          end
          MODE_ONCE: begin
            if (!done) begin
              if (at_top_c) begin
                done <= 1'b1;
              end else begin
                frame        <= frame + FRAME_W'(1);
                frame_strobe <= 1'b1;
              end
            end
          end
          default: begin
`ifdef ANIM_SEQ_LFSR_EN
            frame        <= rand_frame_c;
            frame_strobe <= 1'b1;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anim_frame_sequencer.sv
// Directed self-checking bench for anim_frame_sequencer (default build: mode 11 = hold).
`timescale 1ns/1ps
module tb_anim_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [4:0]  animation;
  logic [1:0]  mode;
  logic [23:0] tick_div;
  logic [4:0]  frame;
  logic        frame_strobe;
  logic        done;
  logic [5:0]  limit;

  int n_cmp = 0;
  int n_bad = 0;

  anim_frame_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .animation    (animation),
    .mode         (mode),
    .tick_div     (tick_div),
    .frame        (frame),
    .frame_strobe (frame_strobe),
    .done         (done),
    .limit        (limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fs(input string tag, input int f, input int s);
    check({tag, ".frame"}, int'(frame), f);
    check({tag, ".strobe"}, int'(frame_strobe), s);
  endtask

  int pp6 [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
  int pp2 [3]  = '{1, 0, 1};

  initial begin
    rst = 1'b1; ena = 1'b0; animation = 5'd0; mode = 2'b00; tick_div = 24'd0;
    tick();
    check_fs("reset", 0, 0);
    check("reset.done", int'(done), 0);
    check("reset.limit", int'(limit), 10);

    // Loop, limit 10, step every cycle
    rst = 1'b0; ena = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_fs($sformatf("loop10[%0d]", i), i % 10, 1);
    end
    check("loop10.limit", int'(limit), 10);

    // Prescaled loop, limit 12, step every 4 cycles
    animation = 5'd1; tick_div = 24'd3;
    tick();
    check_fs("pre.restart", 0, 1);
    check("pre.limit", int'(limit), 12);
    for (int s = 1; s <= 12; s++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        check_fs($sformatf("pre.idle[%0d.%0d]", s, k), (s - 1) % 12, 0);
      end
      tick();
      check_fs($sformatf("pre.step[%0d]", s), s % 12, 1);
    end

    // Ping-pong, limit 6 then limit 2
    tick_div = 24'd0; animation = 5'd2; mode = 2'b01;
    tick();
    check_fs("pp6.restart", 0, 1);
    for (int i = 0; i < 11; i++) begin
      tick();
      check_fs($sformatf("pp6[%0d]", i), pp6[i], 1);
    end
    animation = 5'd7;
    tick();
    check_fs("pp2.restart", 0, 1);
    check("pp2.limit", int'(limit), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fs($sformatf("pp2[%0d]", i), pp2[i], 1);
    end

    // One-shot, limit 4
    animation = 5'd8; mode = 2'b10;
    tick();
    check_fs("once4.restart", 0, 1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_fs($sformatf("once4[%0d]", i), i, 1);
      check($sformatf("once4.done[%0d]", i), int'(done), 0);
    end
    tick();
    check_fs("once4.fin", 3, 0);
    check("once4.done", int'(done), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_fs($sformatf("once4.after[%0d]", i), 3, 0);
      check($sformatf("once4.sticky[%0d]", i), int'(done), 1);
    end

    // One-shot, limit 1: restart clears done, first step sets it
    animation = 5'd27;
    tick();
    check_fs("once1.restart", 0, 1);
    check("once1.done0", int'(done), 0);
    check("once1.limit", int'(limit), 1);
    tick();
    check_fs("once1.step", 0, 0);
    check("once1.done1", int'(done), 1);

    // Hold: frame frozen, no strobes
    animation = 5'd2; mode = 2'b11;
    tick();
    check_fs("hold.restart", 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_fs($sformatf("hold[%0d]", i), 0, 0);
    end

    // Restart colliding with a due step (tick_div=2)
    animation = 5'd0; mode = 2'b00; tick_div = 24'd2;
    tick();
    check_fs("col.restart", 0, 1);
    for (int i = 0; i < 17; i++) tick();
    check_fs("col.pre", 5, 0);
    animation = 5'd16;
    tick();
    check_fs("col.hit", 0, 1);
    check("col.limit", int'(limit), 6);
    tick();
    check_fs("col.p1", 0, 0);
    tick();
    check_fs("col.p2", 0, 0);
    tick();
    check_fs("col.step", 1, 1);

    // Freeze with ena=0 at frame 3
    tick_div = 24'd0;
    tick();
    tick();
    check_fs("frz.pre", 3, 1);
    ena = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_fs($sformatf("frz[%0d]", i), 3, 0);
    end
    ena = 1'b1;
    tick();
    check_fs("frz.resume", 4, 1);

    // Mid-run reset
    rst = 1'b1;
    tick();
    check_fs("rst.mid", 0, 0);
    check("rst.done", int'(done), 0);
    check("rst.limit", int'(limit), 10);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/anim_frame_sequencer.md
Name: anim_frame_sequencer

Overview:
Parametrised frame sequencer for the 7-segment animation engine. It holds the per-animation frame-count table internally and steps a frame index at a programmable rate. Supported modes are loop, ping-pong, one-shot and hold, with clean restart on any animation or mode change. The frame index drives the segment-pattern ROM downstream; this block replaces the bare limit lookup plus the external free-running counter.

Parameters:
ANIM_W, 5, animation select width; indices >= 32 map to limit 1
FRAME_W, 5, frame index width; internal limit held at FRAME_W+1 bits (limit 32 must be representable)
PRESCALE_W, 24, width of rate divider and tick_div input

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ena  in  1  advance enable; 0 freezes prescaler and frame
animation  in  ANIM_W  animation select
mode  in  2  00 loop, 01 ping-pong, 10 one-shot, 11 hold
tick_div  in  PRESCALE_W  step period minus 1, in clk cycles
frame  out  FRAME_W  current frame index, registered
frame_strobe  out  1  one-cycle pulse on each frame update
done  out  1  one-shot finished (sticky until restart)
limit  out  FRAME_W+1  frame count of the latched animation, combinational from latched select

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Limit table, indices 0..31 in order:
  - 10,12,6,6,6,6,6,2,4,4,2,2,2,2,2,4,6,2,7,7,7,7,7,4,16,16,16,1,1,1,1,32
  - Any index >= 32 gives limit 1.
- Reset values:
  - frame=0, frame_strobe=0, done=0.
  - Direction=up, prescaler=0.
  - anim_q=0, mode_q=00.
- Restart: when animation!=anim_q or mode!=mode_q, on that edge:
  - Latch both inputs; frame<=0, direction<=up, prescaler<=0, done<=0.
  - frame_strobe<=1.
  - Restart beats a coincident step. Restart is independent of ena.
  - Result visible 1 cycle after the input change.
- Prescaler:
  - When ena=1 and not restarting, counts 0..tick_div.
  - On the cycle it equals tick_div, it asserts internal step and wraps to 0.
  - tick_div=0 steps every cycle.
  - tick_div changes take effect immediately; if prescaler > new tick_div, it counts to all-ones and wraps (no special handling).
- Step action (frame updated on the step edge; frame_strobe=1 for that cycle):
  - loop: frame = (frame==limit-1) ? 0 : frame+1.
  - ping-pong:
    - Going up: at limit-1, switch to down and emit limit-2.
    - Going down: at 0, switch to up and emit 1.
    - limit 1: stays 0. limit 2: alternates 0,1.
  - one-shot:
    - Increment while frame<limit-1.
    - On the step where frame==limit-1, set done=1 with no strobe; frame holds.
    - Further steps are ignored.
    - limit 1: the first step sets done.
  - hold: frame frozen, no strobe, prescaler still runs.
- frame_strobe is 0 on every non-step, non-restart cycle.
- ena=0: prescaler and frame hold; done holds.
- rst asserted mid-run forces all reset values on that edge, overriding restart and step.

Optional Feature:
Macro ANIM_SEQ_LFSR_EN.
- Defined: mode 11 becomes random instead of hold.
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset seed 8'h01, advances once per step.
  - Candidate c = lfsr[FRAME_W-1:0] after the advance.
  - frame = c if c<limit; else c-limit if that is < limit; else 0. Strobe as in loop mode.
  - The LFSR is not reseeded on restart.
- Undefined: mode 11 is hold and no LFSR logic is present.

Test Plan:
- Loop, limit 10: rst, then animation=0, mode=00, tick_div=0, ena=1 -> frame 0,1..9,0 on consecutive cycles, frame_strobe high each cycle, limit=10.
- Prescale and wrap: animation=1, tick_div=3 -> frame advances every 4 cycles; after 11 steps frame=11, next step frame=0.
- Ping-pong:
  - animation=2 (limit 6), mode=01 -> frames 0,1,2,3,4,5,4,3,2,1,0,1.
  - animation=7 (limit 2) -> 0,1,0,1.
- One-shot:
  - animation=8 (limit 4), mode=10 -> 0,1,2,3, then done=1 on the next step; no further strobes.
  - Switch to animation=27 -> next cycle frame=0, done=0, strobe=1; first step sets done=1.
- Restart collision: loop, animation=0 at frame 5 with step due, animation changed to 16 in the same cycle -> frame=0 (not 6), prescaler=0, limit=6.
- Freeze and reset: ena=0 for 20 cycles at frame 3 -> frame stays 3, no strobe. Assert rst one cycle mid-run -> frame=0, done=0, limit=10 next cycle.
